// File: rtl/mem_rw_requester.sv
// mem_rw_requester: one-outstanding request/response bridge to a word-indexed memory.
// Define MEM_RW_REQUESTER_RANGE_CHECK_EN to reject addresses outside the RAM window.
module mem_rw_requester #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter logic [63:0] RAM_BYTES = 64'd1610612736
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        r_enable,
   output logic [63:0] r_index,
   input  logic [63:0] r_data,
   output logic        w_enable,
   output logic [63:0] w_index,
   output logic [63:0] w_data,
   output logic [63:0] w_mask
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RDATA,
      WR,
      RESP
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [63:0] req_idx;
   logic [63:0] idx_q;
   logic [63:0] wdata_q;
   logic [7:0]  strb_q;
   logic [63:0] mask_exp;
   logic        accept;
   logic        bad_addr;

   if (RAM_BYTES[2:0] != 3'd0) begin : g_bad_ram_bytes
      $error("RAM_BYTES must be a whole number of 64-bit words");
   end

   assign req_idx = (req_addr - BASE_ADDR) >> 3;
   assign accept  = (state_q == IDLE) && req_valid;

`ifdef MEM_RW_REQUESTER_RANGE_CHECK_EN
   localparam logic [63:0] RAM_END = BASE_ADDR + RAM_BYTES;

   logic err_q;

   assign bad_addr = (req_addr < BASE_ADDR) || (req_addr >= RAM_END);
   assign resp_err = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= bad_addr;
      end
   end
`else
   assign bad_addr = 1'b0;
   assign resp_err = 1'b0;
`endif

   for (genvar i = 0; i < 8; i++) begin : g_mask
      assign mask_exp[8*i +: 8] = {8{strb_q[i]}};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (bad_addr) begin
                  state_d = RESP;
               end else if (req_wen) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:    state_d = RDATA;
         RDATA: state_d = RESP;
         WR:    state_d = RESP;
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      r_enable   = 1'b0;
      r_index    = '0;
      w_enable   = 1'b0;
      w_index    = '0;
      w_data     = '0;
      w_mask     = '0;
      unique case (state_q)
         IDLE: req_ready = 1'b1;
         RD: begin
            r_enable = 1'b1;
            r_index  = idx_q;
         end
         RDATA: ;
         WR: begin
            w_enable = 1'b1;
            w_index  = idx_q;
            w_data   = wdata_q;
            w_mask   = mask_exp;
         end
         RESP: resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Response data is cleared on accept so writes and errors answer 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_q      <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         resp_rdata <= '0;
      end else begin
         if (accept) begin
            idx_q      <= req_idx;
            wdata_q    <= req_wdata;
            strb_q     <= req_wstrb;
            resp_rdata <= '0;
         end
         if (state_q == RDATA) begin
            resp_rdata <= r_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_rw_requester.sv
// tb_mem_rw_requester: randomized and directed checks of mem_rw_requester
// against a transaction-level model of address, mask, latency and data.
module tb_mem_rw_requester;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] RAM  = 64'd1610612736;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        r_enable;
   logic [63:0] r_index;
   logic [63:0] r_data;
   logic        w_enable;
   logic [63:0] w_index;
   logic [63:0] w_data;
   logic [63:0] w_mask;

   int compared = 0;
   int mismatched = 0;

   mem_rw_requester #(
      .BASE_ADDR(BASE),
      .RAM_BYTES(RAM)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wen(req_wen),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_wstrb(req_wstrb),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .r_enable(r_enable),
      .r_index(r_index),
      .r_data(r_data),
      .w_enable(w_enable),
      .w_index(w_index),
      .w_data(w_data),
      .w_mask(w_mask)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] mem_f(input logic [63:0] i);
      return {i[31:0] ^ 32'hC3A5_5A3C, i[63:32] ^ ~i[31:0]};
   endfunction

   // Memory: data valid the cycle after the strobe, garbage otherwise.
   logic        ovr_en = 1'b0;
   logic [63:0] ovr_data = '0;
   always @(posedge clock) begin
      if (r_enable) r_data <= ovr_en ? ovr_data : mem_f(r_index);
      else r_data <= {$urandom, $urandom};
   end

   int cyc = 0;
   int r_cnt, w_cnt, rv_cnt;
   int excl_bad = 0;
   int idle_bad = 0;
   logic [63:0] r_idx_seen, w_idx_seen, w_data_seen, w_mask_seen;
   int req_hs_q[$];
   int resp_hs_q[$];

   always @(negedge clock) begin
      cyc++;
      if (r_enable) begin
         r_cnt++;
         r_idx_seen = r_index;
      end
      if (w_enable) begin
         w_cnt++;
         w_idx_seen = w_index;
         w_data_seen = w_data;
         w_mask_seen = w_mask;
      end
      if (r_enable && w_enable) excl_bad++;
      if (!r_enable && r_index != 0) idle_bad++;
      if (!w_enable && (w_index | w_data | w_mask) != 0) idle_bad++;
      if (resp_valid) rv_cnt++;
      if (req_valid && req_ready) req_hs_q.push_back(cyc);
      if (resp_valid && resp_ready) resp_hs_q.push_back(cyc);
   end

   task automatic clear_log();
      r_cnt = 0;
      w_cnt = 0;
      rv_cnt = 0;
      r_idx_seen = '0;
      w_idx_seen = '0;
      w_data_seen = '0;
      w_mask_seen = '0;
      req_hs_q.delete();
      resp_hs_q.delete();
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Expected outcome from the address map and strobe rules.
   function automatic void model(
      input logic [63:0] addr, input logic wen, input logic [7:0] wstrb,
      output logic err, output logic [63:0] idx,
      output logic [63:0] mask, output int lat);
      err = 1'b0;
`ifdef MEM_RW_REQUESTER_RANGE_CHECK_EN
      err = (addr < BASE) || (addr >= BASE + RAM);
`endif
      idx = (addr - BASE) / 64'd8;
      mask = '0;
      for (int i = 0; i < 8; i++)
         if (wstrb[i]) mask |= 64'hFF << (8 * i);
      lat = err ? 1 : (wen ? 2 : 3);
   endfunction

   task automatic drive_txn(
      input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
      input logic [7:0] wstrb, input int hold,
      output int lat, output logic [63:0] rdata, output logic err,
      output bit stable, output bit tmo);
      int n;
      clear_log();
      tmo = 0;
      stable = 1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      req_valid = 1'b1;
      req_wen = wen;
      req_addr = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      tick();
      req_valid = 1'b0;
      req_wen = 1'($urandom);
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      n = 1;
      while (!resp_valid && n < 20) begin
         tick();
         n++;
      end
      tmo = !resp_valid;
      lat = n;
      rdata = resp_rdata;
      err = resp_err;
      if (!tmo) begin
         req_valid = 1'b1;
         repeat (hold) begin
            tick();
            if (!resp_valid || resp_rdata !== rdata || resp_err !== err || req_ready)
               stable = 0;
         end
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      if (resp_valid || !req_ready) stable = 0;
   endtask

   task automatic test_reset();
      tick(3);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", req_ready); end
      compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_rvalid got %b want 0", resp_valid); end
      compared++; if (resp_rdata !== 64'h0) begin mismatched++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
      compared++; if (resp_err !== 1'b0) begin mismatched++; $display("FAIL rst_err got %b want 0", resp_err); end
      compared++; if ({r_enable, w_enable} !== 2'b00) begin mismatched++; $display("FAIL rst_strobes got %b want 00", {r_enable, w_enable}); end
      compared++; if ((r_index | w_index | w_data | w_mask) !== 64'h0) begin mismatched++; $display("FAIL rst_buses got nonzero want 0"); end
   endtask

   task automatic test_read();
      int lat;
      logic [63:0] rd;
      logic er;
      bit st, to;
      ovr_en = 1'b1;
      ovr_data = 64'hDEAD_BEEF_0123_4567;
      drive_txn(1'b0, 64'h8000_0010, 64'h0, 8'h00, 0, lat, rd, er, st, to);
      ovr_en = 1'b0;
      compared++; if (to) begin mismatched++; $display("FAIL rd_timeout got timeout want resp_valid"); end
      compared++; if (lat !== 3) begin mismatched++; $display("FAIL rd_lat got %0d want 3", lat); end
      compared++; if (rd !== 64'hDEAD_BEEF_0123_4567) begin mismatched++; $display("FAIL rd_data got %h want deadbeef01234567", rd); end
      compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL rd_err got %b want 0", er); end
      compared++; if (r_cnt !== 1 || w_cnt !== 0) begin mismatched++; $display("FAIL rd_strobes got r%0d w%0d want r1 w0", r_cnt, w_cnt); end
      compared++; if (r_idx_seen !== 64'd2) begin mismatched++; $display("FAIL rd_index got %h want 2", r_idx_seen); end
   endtask

   task automatic test_write();
      int lat;
      logic [63:0] rd;
      logic er;
      bit st, to;
      drive_txn(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F, 0, lat, rd, er, st, to);
      compared++; if (to || lat !== 2) begin mismatched++; $display("FAIL wr_lat got %0d want 2", lat); end
      compared++; if (rd !== 64'h0) begin mismatched++; $display("FAIL wr_rdata got %h want 0", rd); end
      compared++; if (w_cnt !== 1 || r_cnt !== 0) begin mismatched++; $display("FAIL wr_strobes got r%0d w%0d want r0 w1", r_cnt, w_cnt); end
      compared++; if (w_idx_seen !== 64'd1) begin mismatched++; $display("FAIL wr_index got %h want 1", w_idx_seen); end
      compared++; if (w_data_seen !== 64'h1122_3344_5566_7788) begin mismatched++; $display("FAIL wr_data got %h want 1122334455667788", w_data_seen); end
      compared++; if (w_mask_seen !== 64'h0000_0000_FFFF_FFFF) begin mismatched++; $display("FAIL wr_mask got %h want 00000000ffffffff", w_mask_seen); end
      drive_txn(1'b1, 64'h8000_0100, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, 0, lat, rd, er, st, to);
      compared++; if (w_cnt !== 1 || w_mask_seen !== 64'h0) begin mismatched++; $display("FAIL wr_strb0 got w%0d mask %h want w1 mask 0", w_cnt, w_mask_seen); end
   endtask

   task automatic test_stall();
      int lat;
      logic [63:0] rd;
      logic er;
      bit st, to;
      drive_txn(1'b0, 64'h8000_0040, 64'h0, 8'h00, 5, lat, rd, er, st, to);
      compared++; if (!st || to) begin mismatched++; $display("FAIL stall_stable got %0d want 1", st); end
      compared++; if (r_cnt !== 1 || w_cnt !== 0) begin mismatched++; $display("FAIL stall_strobes got r%0d w%0d want r1 w0", r_cnt, w_cnt); end
      compared++; if (req_hs_q.size() !== 1) begin mismatched++; $display("FAIL stall_accepts got %0d want 1", req_hs_q.size()); end
      compared++; if (rd !== mem_f(64'd8)) begin mismatched++; $display("FAIL stall_data got %h want %h", rd, mem_f(64'd8)); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [63:0] rd;
      logic er;
      bit st, to;
      clear_log();
      req_valid = 1'b1;
      req_wen = 1'b0;
      req_addr = 64'h8000_0080;
      tick();
      req_valid = 1'b0;
      compared++; if (r_enable !== 1'b1) begin mismatched++; $display("FAIL mid_pre got %b want 1", r_enable); end
      #2 reset_n = 1'b0;
      #1;
      compared++; if (r_enable !== 1'b0 || r_index !== 64'h0) begin mismatched++; $display("FAIL mid_drop got %b %h want 0 0", r_enable, r_index); end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready got %b want 1", req_ready); end
      clear_log();
      tick(4);
      compared++; if (rv_cnt + r_cnt + w_cnt !== 0) begin mismatched++; $display("FAIL mid_silent got rv%0d r%0d w%0d want 0", rv_cnt, r_cnt, w_cnt); end
      drive_txn(1'b0, 64'h8000_0018, 64'h0, 8'h00, 1, lat, rd, er, st, to);
      compared++; if (to || lat !== 3 || rd !== mem_f(64'd3)) begin mismatched++; $display("FAIL mid_next got lat %0d data %h want 3 %h", lat, rd, mem_f(64'd3)); end
   endtask

   task automatic test_range();
      logic [63:0] addrs [4];
      int lat, elat;
      logic [63:0] rd, eidx, emask;
      logic er, eerr;
      bit st, to;
      addrs[0] = 64'h7FFF_FFF8;
      addrs[1] = 64'hE000_0000;
      addrs[2] = BASE + RAM - 64'd8;
      addrs[3] = 64'h0;
      for (int i = 0; i < 4; i++) begin
         model(addrs[i], 1'b0, 8'h00, eerr, eidx, emask, elat);
         drive_txn(1'b0, addrs[i], 64'h0, 8'h00, 1, lat, rd, er, st, to);
         compared++; if (to || lat !== elat || er !== eerr) begin mismatched++; $display("FAIL range%0d got lat %0d err %b want %0d %b", i, lat, er, elat, eerr); end
         compared++; if (r_cnt !== (eerr ? 0 : 1) || w_cnt !== 0) begin mismatched++; $display("FAIL range%0d_strobes got r%0d w%0d want r%0d", i, r_cnt, w_cnt, eerr ? 0 : 1); end
         compared++; if (rd !== (eerr ? 64'h0 : mem_f(eidx))) begin mismatched++; $display("FAIL range%0d_data got %h", i, rd); end
         if (!eerr) begin
            compared++; if (r_idx_seen !== eidx) begin mismatched++; $display("FAIL range%0d_index got %h want %h", i, r_idx_seen, eidx); end
         end
      end
   endtask

   task automatic test_random();
      int lat, elat, hold;
      logic [63:0] addr, wd, rd, eidx, emask;
      logic [7:0] ws;
      logic wen, er, eerr;
      bit st, to;
      for (int k = 0; k < 40; k++) begin
         wen = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 7)
            addr = BASE + 64'($urandom_range(0, 201326591)) * 64'd8 + 64'($urandom_range(0, 7));
         else
            addr = {$urandom, $urandom};
         wd = {$urandom, $urandom};
         ws = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         hold = $urandom_range(0, 3);
         model(addr, wen, ws, eerr, eidx, emask, elat);
         drive_txn(wen, addr, wd, ws, hold, lat, rd, er, st, to);
         compared++; if (to || !st || lat !== elat || er !== eerr) begin mismatched++; $display("FAIL rnd%0d_resp got lat %0d err %b st %0d want %0d %b", k, lat, er, st, elat, eerr); end
         compared++; if (rd !== ((eerr || wen) ? 64'h0 : mem_f(eidx))) begin mismatched++; $display("FAIL rnd%0d_data got %h", k, rd); end
         compared++; if (r_cnt !== ((!eerr && !wen) ? 1 : 0) || w_cnt !== ((!eerr && wen) ? 1 : 0)) begin mismatched++; $display("FAIL rnd%0d_strobes got r%0d w%0d", k, r_cnt, w_cnt); end
         if (!eerr && !wen) begin
            compared++; if (r_idx_seen !== eidx) begin mismatched++; $display("FAIL rnd%0d_rindex got %h want %h", k, r_idx_seen, eidx); end
         end
         if (!eerr && wen) begin
            compared++; if ({w_idx_seen, w_data_seen, w_mask_seen} !== {eidx, wd, emask}) begin mismatched++; $display("FAIL rnd%0d_write got %h %h %h want %h %h %h", k, w_idx_seen, w_data_seen, w_mask_seen, eidx, wd, emask); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      clear_log();
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_wen = 1'b0;
      req_addr = 64'h8000_0020;
      tick();
      req_wen = 1'b1;
      req_addr = 64'h8000_0028;
      req_wdata = 64'h0BAD_F00D_CAFE_1234;
      req_wstrb = 8'hF0;
      n = 0;
      while (req_hs_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      req_valid = 1'b0;
      n = 0;
      while (resp_hs_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      resp_ready = 1'b0;
      tick();
      compared++;
      if (req_hs_q.size() != 2 || resp_hs_q.size() != 2) begin
         mismatched++;
         $display("FAIL b2b_count got req %0d resp %0d want 2 2", req_hs_q.size(), resp_hs_q.size());
         return;
      end
      compared++; if (resp_hs_q[0] - req_hs_q[0] !== 3) begin mismatched++; $display("FAIL b2b_rdlat got %0d want 3", resp_hs_q[0] - req_hs_q[0]); end
      compared++; if (req_hs_q[1] - resp_hs_q[0] !== 1) begin mismatched++; $display("FAIL b2b_gap got %0d want 1", req_hs_q[1] - resp_hs_q[0]); end
      compared++; if (resp_hs_q[1] - req_hs_q[1] !== 2) begin mismatched++; $display("FAIL b2b_wrlat got %0d want 2", resp_hs_q[1] - req_hs_q[1]); end
      compared++; if (r_cnt !== 1 || w_cnt !== 1) begin mismatched++; $display("FAIL b2b_strobes got r%0d w%0d want r1 w1", r_cnt, w_cnt); end
      compared++; if (r_idx_seen !== 64'd4 || w_idx_seen !== 64'd5 || w_mask_seen !== 64'hFFFF_FFFF_0000_0000) begin mismatched++; $display("FAIL b2b_fields got %h %h %h", r_idx_seen, w_idx_seen, w_mask_seen); end
   endtask

   task automatic test_invariants();
      compared++; if (excl_bad !== 0) begin mismatched++; $display("FAIL excl got %0d want 0", excl_bad); end
      compared++; if (idle_bad !== 0) begin mismatched++; $display("FAIL idle_zero got %0d want 0", idle_bad); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_stall();
      test_reset_mid();
      test_range();
      test_random();
      test_back_to_back();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
